game_flow_ctrl: RTL and testbench

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level flow controller for a tilt-maze game.
//
// Sequences IDLE -> READY -> PLAYING -> FAIL/WIN -> READY/OVER/CLEARED and
// tracks level, lives and score. A frame counter, cleared on every state entry,
// times the READY and FAIL/WIN hold phases.
//
// Optional feature: define GAME_TIMEOUT_EN to fail the level after
// TIMEOUT_FRAMES frame strobes spent in PLAYING.
//
// Ports:
//   CLK            clock
//   rst_n          asynchronous active-low reset
//   i_restart      restart request (overrides everything)
//   i_screenend    one-cycle frame strobe
//   i_accel_ready  accelerometer data valid (starts the game from IDLE)
//   i_win, i_fail  ball in win hole / fail hole
//   o_state        current state (IDLE=0 .. CLEARED=6)
//   o_playing      high while in PLAYING
//   o_level        current level
//   o_lives        remaining lives
//   o_ball_sel     0 = home, 1 = rolling, 2 = fixed at hole
//   o_game_rst     one-cycle pulse on the first cycle of READY
//   o_score        saturating count of cleared levels
module game_flow_ctrl #(
  parameter int unsigned READY_FRAMES   = 60,
  parameter int unsigned HOLD_FRAMES    = 120,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned MAX_LEVEL      = 4,
  parameter int unsigned TIMEOUT_FRAMES = 1800
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_restart,
  input  logic       i_screenend,
  input  logic       i_accel_ready,
  input  logic       i_win,
  input  logic       i_fail,
  output logic [2:0] o_state,
  output logic       o_playing,
  output logic [1:0] o_level,
  output logic [1:0] o_lives,
  output logic [1:0] o_ball_sel,
  output logic       o_game_rst,
  output logic [7:0] o_score
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReady   = 3'd1,
    StPlaying = 3'd2,
    StFail    = 3'd3,
    StWin     = 3'd4,
    StOver    = 3'd5,
    StCleared = 3'd6,
    StUnused  = 3'd7
  } state_e;

  // Counter wide enough for the largest frame threshold in use.
  localparam int unsigned MaxA      = (READY_FRAMES > HOLD_FRAMES) ? READY_FRAMES : HOLD_FRAMES;
  localparam int unsigned MaxFrames = (MaxA > TIMEOUT_FRAMES) ? MaxA : TIMEOUT_FRAMES;
  localparam int unsigned CntW      = $clog2(MaxFrames + 2);

  localparam logic [CntW-1:0] ReadyCnt  = CntW'(READY_FRAMES);
  localparam logic [CntW-1:0] HoldCnt   = CntW'(HOLD_FRAMES);
  localparam logic [1:0]      LivesInit = 2'(LIVES);
  localparam logic [1:0]      LastLevel = 2'(MAX_LEVEL - 1);
`ifdef GAME_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_FRAMES);
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            entry_q;
  logic            enter;
  logic [1:0]      level_q, level_d;
  logic [1:0]      lives_q, lives_d;
  logic [7:0]      score_q, score_d;
  logic            playing_q, playing_d;
  logic [1:0]      ball_sel_q, ball_sel_d;
  logic            game_rst_q, game_rst_d;

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      entry_q    <= 1'b0;
      level_q    <= 2'd0;
      lives_q    <= LivesInit;
      score_q    <= 8'd0;
      playing_q  <= 1'b0;
      ball_sel_q <= 2'd0;
      game_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      entry_q    <= enter;
      level_q    <= level_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      playing_q  <= playing_d;
      ball_sel_q <= ball_sel_d;
      game_rst_q <= game_rst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    score_d = score_q;
    if (i_restart) begin
      state_d = StReady;
      level_d = 2'd0;
      lives_d = LivesInit;
      score_d = 8'd0;
    end else begin
      case (state_q)
        StIdle:    if (i_accel_ready) state_d = StReady;
        StReady:   if (cnt_q >= ReadyCnt) state_d = StPlaying;
        StPlaying: begin
          if (i_fail) state_d = StFail;
          else if (i_win) state_d = StWin;
`ifdef GAME_TIMEOUT_EN
          else if (cnt_q >= TimeoutCnt) state_d = StFail;
`endif
        end
        StFail: begin
          if (cnt_q >= HoldCnt) begin
            if (lives_q == 2'd1) begin
              state_d = StOver;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = StReady;
            end
          end
        end
        StWin: begin
          if (cnt_q >= HoldCnt) begin
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            if (level_q == LastLevel) begin
              state_d = StCleared;
            end else begin
              level_d = level_q + 2'd1;
              state_d = StReady;
            end
          end
        end
        StOver, StCleared: state_d = state_q;
        default:           state_d = StIdle;
      endcase
    end

    // Restart into READY counts as an entry even when already in READY.
    enter = i_restart || (state_d != state_q);

    // A strobe in the entry cycle is dropped so each phase counts whole frames.
    if (enter) begin
      cnt_d = '0;
    end else if (!entry_q && i_screenend) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output logic, registered from the next state
  always_comb begin
    playing_d  = (state_d == StPlaying);
    game_rst_d = enter && (state_d == StReady);
    case (state_d)
      StPlaying:                         ball_sel_d = 2'd1;
      StFail, StWin, StOver, StCleared:  ball_sel_d = 2'd2;
      default:                           ball_sel_d = 2'd0;
    endcase
  end

  assign o_state    = state_q;
  assign o_playing  = playing_q;
  assign o_level    = level_q;
  assign o_lives    = lives_q;
  assign o_ball_sel = ball_sel_q;
  assign o_game_rst = game_rst_q;
  assign o_score    = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios followed by
// randomized stimulus, checked against a reference model through a scoreboard.
module tb_game_flow_ctrl;

  localparam int RF = 2;
  localparam int HF = 3;
  localparam int LV = 2;
  localparam int ML = 2;
  localparam int TF = 4;
`ifdef GAME_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  // Game phases as numbered in the interface
  localparam int PIdle = 0, PReady = 1, PPlay = 2, PFail = 3, PWin = 4, POver = 5, PClear = 6;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0, strobe = 1'b0, accel = 1'b0, win = 1'b0, fail = 1'b0;
  logic [2:0] o_state;
  logic       o_playing;
  logic [1:0] o_level, o_lives, o_ball_sel;
  logic       o_game_rst;
  logic [7:0] o_score;

  game_flow_ctrl #(
    .READY_FRAMES  (RF),
    .HOLD_FRAMES   (HF),
    .LIVES         (LV),
    .MAX_LEVEL     (ML),
    .TIMEOUT_FRAMES(TF)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .i_restart    (restart),
    .i_screenend  (strobe),
    .i_accel_ready(accel),
    .i_win        (win),
    .i_fail       (fail),
    .o_state      (o_state),
    .o_playing    (o_playing),
    .o_level      (o_level),
    .o_lives      (o_lives),
    .o_ball_sel   (o_ball_sel),
    .o_game_rst   (o_game_rst),
    .o_score      (o_score)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int st;
    int lvl;
    int lives;
    int score;
    int ball;
    int playing;
    int grst;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: phase, frames counted in the phase, whether this is
  // the phase's first cycle, and game progress.
  int m_phase, m_frames, m_lvl, m_lives, m_score;
  bit m_first, m_entered;

  function automatic void model_reset();
    m_phase = PIdle; m_frames = 0; m_lvl = 0; m_lives = LV; m_score = 0;
    m_first = 1'b0; m_entered = 1'b0;
  endfunction

  function automatic void model_step(bit r, bit s, bit a, bit w, bit f);
    int nxt;
    nxt = m_phase;
    if (r) begin
      nxt = PReady; m_lvl = 0; m_lives = LV; m_score = 0;
    end else if (m_phase == PIdle) begin
      if (a) nxt = PReady;
    end else if (m_phase == PReady) begin
      if (m_frames >= RF) nxt = PPlay;
    end else if (m_phase == PPlay) begin
      if (f || w) nxt = f ? PFail : PWin;
      else if (TimeoutOn && m_frames >= TF) nxt = PFail;
    end else if (m_phase == PFail) begin
      if (m_frames >= HF) begin
        if (m_lives == 1) nxt = POver;
        else begin m_lives = m_lives - 1; nxt = PReady; end
      end
    end else if (m_phase == PWin) begin
      if (m_frames >= HF) begin
        m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
        if (m_lvl == ML - 1) nxt = PClear;
        else begin m_lvl = m_lvl + 1; nxt = PReady; end
      end
    end
    m_entered = r || (nxt != m_phase);
    if (m_entered) m_frames = 0;
    else if (!m_first && s) m_frames = m_frames + 1;
    m_first = m_entered;
    m_phase = nxt;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st      = m_phase;
    e.lvl     = m_lvl;
    e.lives   = m_lives;
    e.score   = m_score;
    e.playing = (m_phase == PPlay) ? 1 : 0;
    e.ball    = (m_phase == PPlay) ? 1 : (m_phase >= PFail) ? 2 : 0;
    e.grst    = (m_entered && m_phase == PReady) ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every posedge the DUT presents its registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",    int'(o_state),    e.st);
        check("level",    int'(o_level),    e.lvl);
        check("lives",    int'(o_lives),    e.lives);
        check("score",    int'(o_score),    e.score);
        check("ball_sel", int'(o_ball_sel), e.ball);
        check("playing",  int'(o_playing),  e.playing);
        check("game_rst", int'(o_game_rst), e.grst);
      end
    end
  end

  task automatic cyc(input bit r, input bit s, input bit a, input bit w, input bit f);
    @(negedge CLK);
    restart = r; strobe = s; accel = a; win = w; fail = f;
    model_step(r, s, a, w, f);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n, input bit s);
    repeat (n) cyc(1'b0, s, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges, check it acts at once, hold across one
  // posedge, release on the following negedge.
  task automatic do_reset();
    @(negedge CLK);
    restart = 0; strobe = 0; accel = 0; win = 0; fail = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state",    int'(o_state),    0);
    check("async_rst_level",    int'(o_level),    0);
    check("async_rst_lives",    int'(o_lives),    LV);
    check("async_rst_score",    int'(o_score),    0);
    check("async_rst_ball_sel", int'(o_ball_sel), 0);
    check("async_rst_playing",  int'(o_playing),  0);
    check("async_rst_game_rst", int'(o_game_rst), 0);
    model_reset();
    exp_q.push_back(model_out());
    @(negedge CLK);
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_out());
  endtask

  initial begin
    model_reset();
    do_reset();
    // Start path; strobe in READY entry cycle must be ignored
    run(2, 1'b1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    run(2, 1'b1);
    run(2, 1'b0);
    // Fail twice to game over
    cyc(0, 0, 0, 0, 1);
    run(6, 1'b1);
    run(6, 1'b1);
    cyc(0, 0, 0, 0, 1);
    run(6, 1'b1);
    run(3, 1'b0);
    // Restart, simultaneous win+fail, restart with fail
    cyc(1, 0, 0, 0, 0);
    run(5, 1'b1);
    cyc(0, 0, 0, 1, 1);
    run(2, 1'b1);
    cyc(1, 0, 0, 0, 1);
    run(5, 1'b1);
    // Win to cleared
    cyc(0, 0, 0, 1, 0);
    run(6, 1'b1);
    run(5, 1'b1);
    cyc(0, 0, 0, 1, 0);
    run(6, 1'b1);
    run(3, 1'b1);
    // Reset in the middle of a WIN hold
    cyc(1, 0, 0, 0, 0);
    run(5, 1'b1);
    cyc(0, 0, 0, 1, 0);
    run(2, 1'b1);
    do_reset();
    run(3, 1'b1);
    cyc(0, 1, 0, 1, 1);
    run(2, 1'b0);
    // Long play: timeout (if enabled) or stays in PLAYING
    cyc(0, 0, 1, 0, 0);
    run(5, 1'b1);
    run(10, 1'b1);
    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(63) == 0), ($urandom_range(1) == 0), ($urandom_range(3) == 0),
            ($urandom_range(15) == 0), ($urandom_range(19) == 0));
      end
    end
    @(negedge CLK);
    restart = 0; strobe = 0; accel = 0; win = 0; fail = 0;
    repeat (3) @(posedge CLK);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
